// File: rtl/mul_unit.sv
// Multi-cycle unsigned shift-add multiplier returning one product half as a register-file write.
// Optional MUL_EARLY_EXIT_EN: leave BUSY as soon as the remaining multiplier bits are all zero.
module mul_unit #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Hi,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [1:0]   Dest,
    output logic         Busy,
    output logic         Reg_w,
    output logic [1:0]   Waddr,
    output logic [n-1:0] Wdata,
    output logic [1:0]   dbg_state
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*n-1:0]  acc_q, acc_d;
    logic [2*n-1:0]  mcand_q, mcand_d;
    logic [n-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      dest_q, dest_d;
    logic            hi_q, hi_d;
    logic [n-1:0]    wdata_q, wdata_d;
    logic            last_cycle;

    // Handshake: Start acts as valid and is only accepted while Busy is low (IDLE);
    // Busy is the inverted ready and is never queued against.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        count_d    = count_q;
        dest_d     = dest_q;
        hi_d       = hi_q;
        wdata_d    = wdata_q;
        last_cycle = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    acc_d    = '0;
                    mcand_d  = {{n{1'b0}}, A};
                    mplier_d = B;
                    count_d  = '0;
                    dest_d   = Dest;
                    hi_d     = Hi;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d    = mcand_q << 1;
                mplier_d   = mplier_q >> 1;
                count_d    = count_q + 1'b1;
                last_cycle = (count_q == LAST_COUNT);
`ifdef MUL_EARLY_EXIT_EN
                last_cycle = last_cycle | (mplier_d == '0);
`endif
                if (last_cycle) begin
                    state_d = DONE;
                    // acc_d already holds the final product in the exit cycle.
                    wdata_d = hi_q ? acc_d[2*n-1:n] : acc_d[n-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            dest_q   <= '0;
            hi_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            dest_q   <= dest_d;
            hi_q     <= hi_d;
            wdata_q  <= wdata_d;
        end
    end

    // r0 is hard-wired, so a DONE targeting it produces no strobe.
    assign Busy      = (state_q != IDLE);
    assign Reg_w     = (state_q == DONE) && (dest_q != 2'd0);
    assign Waddr     = (state_q == DONE) ? dest_q : 2'd0;
    assign Wdata     = wdata_q;
    assign dbg_state = state_q;

endmodule
